ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch.sv | 131 +++++++++++++
 tb/tb_ifetch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC, request/response FSM, commit counter (option: IFETCH_ALIGN_CHECK_EN)
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] niaddr,
    input  logic        stall,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic [31:0] iaddr,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        fault,
    output logic [31:0] ins_count
);

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] ins_q, ins_n;
    logic        ins_valid_q, ins_valid_n;
    logic        ireq_valid_q, ireq_valid_n;
    logic [31:0] count_q, count_n;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fault_q, fault_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            ins_q        <= 32'h0;
            ins_valid_q  <= 1'b0;
            ireq_valid_q <= 1'b0;
            count_q      <= 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            ins_q        <= ins_n;
            ins_valid_q  <= ins_valid_n;
            ireq_valid_q <= ireq_valid_n;
            count_q      <= count_n;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q      <= fault_n;
`endif
        end
    end

    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        ins_n        = ins_q;
        ins_valid_n  = ins_valid_q;
        ireq_valid_n = ireq_valid_q;
        count_n      = count_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_n      = fault_q;
`endif
        case (state_q)
            S_REQ: begin
                // Request rises one cycle after entering REQ from reset and is then held until accepted.
                if (!ireq_valid_q) begin
                    ireq_valid_n = 1'b1;
                end else if (ireq_ready) begin
                    ireq_valid_n = 1'b0;
                    state_n      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (iresp_valid) begin
                    ins_n       = iresp_data;
                    ins_valid_n = 1'b1;
                    state_n     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ins_ready && !stall) begin
                    count_n     = count_q + 32'h1;
                    ins_valid_n = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (niaddr[1:0] != 2'b00) begin
                        fault_n      = 1'b1;
                        ireq_valid_n = 1'b0;
                        state_n      = S_FAULT;
                    end else begin
                        pc_n         = niaddr;
                        ireq_valid_n = 1'b1;
                        state_n      = S_REQ;
                    end
`else
                    pc_n         = niaddr & ~32'h3;
                    ireq_valid_n = 1'b1;
                    state_n      = S_REQ;
`endif
                end
            end
            S_FAULT: begin
                ireq_valid_n = 1'b0;
                ins_valid_n  = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
                fault_n      = 1'b1;
`endif
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
    end

    assign ireq_valid = ireq_valid_q;
    assign ireq_addr  = pc_q;
    assign iaddr      = pc_q;
    assign ins        = ins_q;
    assign ins_valid  = ins_valid_q;
    assign ins_count  = count_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign fault      = fault_q;
`else
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed scoreboard bench for ifetch
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] niaddr;
    logic        stall;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic [31:0] iaddr;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic        fault;
    logic [31:0] ins_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;
    logic [31:0] held_ins;
    logic [63:0] sb[$];

    ifetch dut (
        .clk        (clk),
        .rst        (rst),
        .niaddr     (niaddr),
        .stall      (stall),
        .ireq_valid (ireq_valid),
        .ireq_addr  (ireq_addr),
        .ireq_ready (ireq_ready),
        .iresp_valid(iresp_valid),
        .iresp_data (iresp_data),
        .iaddr      (iaddr),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .fault      (fault),
        .ins_count  (ins_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue-to-capture for one fetch; the memory answers lat cycles after acceptance.
    task automatic fetch(input logic [31:0] exp_addr, input int lat);
        int          w;
        logic [31:0] a;
        logic [63:0] e;
        w = 0;
        while (ireq_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("req_valid", {31'h0, ireq_valid}, 32'h1);
        check("req_addr", ireq_addr, exp_addr);
        a = ireq_addr;
        sb.push_back({exp_addr, mem_word(exp_addr)});
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0;
        check("req_drop", {31'h0, ireq_valid}, 32'h0);
        repeat (lat - 1) tick();
        iresp_valid = 1'b1;
        iresp_data  = mem_word(a);
        tick();
        iresp_valid = 1'b0;
        iresp_data  = 32'h0;
        check("ins_valid", {31'h0, ins_valid}, 32'h1);
        e = sb.pop_front();
        check("iaddr", iaddr, e[63:32]);
        check("ins", ins, e[31:0]);
    endtask

    task automatic commit(input logic [31:0] nia);
        niaddr    = nia;
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        exp_count = exp_count + 32'h1;
        check("commit_count", ins_count, exp_count);
        check("commit_ins_valid", {31'h0, ins_valid}, 32'h0);
    endtask

    task automatic expect_req(input logic [31:0] pc);
        check("next_req_valid", {31'h0, ireq_valid}, 32'h1);
        check("next_req_addr", ireq_addr, pc);
        check("next_iaddr", iaddr, pc);
    endtask

    initial begin
        rst         = 1'b1;
        niaddr      = 32'h0;
        stall       = 1'b0;
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
        iresp_data  = 32'h0;
        ins_ready   = 1'b0;
        exp_count   = 32'h0;

        tick();
        check("rst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
        check("rst_ireq_addr", ireq_addr, 32'h3000);
        check("rst_iaddr", iaddr, 32'h3000);
        check("rst_ins", ins, 32'h0);
        check("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_count", ins_count, 32'h0);
        rst = 1'b0;
        tick();
        check("first_req", {31'h0, ireq_valid}, 32'h1);

        fetch(32'h3000, 1);
        commit(32'h3004);
        expect_req(32'h3004);
        fetch(32'h3004, 2);
        commit(32'h3010);
        expect_req(32'h3010);
        fetch(32'h3010, 1);
        check("count_two", ins_count, 32'h2);

        // Back-pressure with stall raised: stall must not matter in REQ/WAIT.
        commit(32'h3018);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'h0, ireq_valid}, 32'h1);
            check("bp_addr", ireq_addr, 32'h3018);
        end
        fetch(32'h3018, 3);
        ins_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ins_valid", {31'h0, ins_valid}, 32'h1);
            check("stall_count", ins_count, exp_count);
            check("stall_ins", ins, mem_word(32'h3018));
        end
        stall = 1'b0;
        commit(32'h3020);
        expect_req(32'h3020);

        // Spurious responses in REQ and in HOLD.
        iresp_valid = 1'b1;
        iresp_data  = 32'hDEAD_BEEF;
        tick();
        iresp_valid = 1'b0;
        check("spur_req_ins", ins, mem_word(32'h3018));
        check("spur_req_valid", {31'h0, ins_valid}, 32'h0);
        check("spur_req_ireq", {31'h0, ireq_valid}, 32'h1);
        fetch(32'h3020, 1);
        iresp_valid = 1'b1;
        iresp_data  = 32'hCAFE_F00D;
        tick();
        iresp_valid = 1'b0;
        check("spur_hold_ins", ins, mem_word(32'h3020));
        check("spur_hold_valid", {31'h0, ins_valid}, 32'h1);

        // Reset while a fetch is outstanding; the late response must be dropped.
        commit(32'h3024);
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 32'h0;
        check("wrst_iaddr", iaddr, 32'h3000);
        check("wrst_count", ins_count, 32'h0);
        iresp_valid = 1'b1;
        iresp_data  = 32'hBAD0_BAD0;
        tick();
        iresp_valid = 1'b0;
        check("late_ins", ins, 32'h0);
        check("late_ins_valid", {31'h0, ins_valid}, 32'h0);
        check("late_ireq", {31'h0, ireq_valid}, 32'h1);
        fetch(32'h3000, 1);

        // Counter wrap: preload the counter while holding.
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        tick();
        check("preload_count", ins_count, 32'hFFFF_FFFF);
        exp_count = 32'hFFFF_FFFF;
        commit(32'h3004);
        check("wrap_count", ins_count, 32'h0);
        fetch(32'h3004, 1);

        commit(32'h3006);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'h0, fault}, 32'h1);
        check("mis_ireq", {31'h0, ireq_valid}, 32'h0);
        check("mis_iaddr", iaddr, 32'h3004);
        repeat (5) tick();
        check("fault_sticky", {31'h0, fault}, 32'h1);
        check("fault_noreq", {31'h0, ireq_valid}, 32'h0);
        check("fault_ins_valid", {31'h0, ins_valid}, 32'h0);
`else
        check("mis_fault", {31'h0, fault}, 32'h0);
        expect_req(32'h3004);
        fetch(32'h3004, 1);
        commit(32'h3008);
        expect_req(32'h3008);
`endif
        check("sb_empty", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
